// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
//   Shared types and defaults for the FC datapath rate decoder.
//   - dec_state_t : decoder FSM states (IDLE / COUNT / HOLD)
//   - DEF_INWD    : default decoded word width
//   - DEF_WIN_LOG : default log2 of the sampling window length
// -----------------------------------------------------------------------------
package fc_pkg;

    localparam int DEF_INWD    = 8;
    localparam int DEF_WIN_LOG = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } dec_state_t;

endpackage : fc_pkg

// File: rtl/fc_rate_lane.sv
// -----------------------------------------------------------------------------
// fc_rate_lane
//   One decoder lane: counts ones of a rate-coded bitstream over a window and
//   captures the (saturated) count into an output register.
//
//   clk      in  : clock, rising edge
//   rst      in  : asynchronous active-high reset
//   i_clear  in  : clear the ones counter (new window)
//   i_sample in  : take the current bit into the counter
//   i_bit    in  : stream bit for this lane
//   i_load   in  : last sample of the window; capture count + bit into o_out
//   o_out    out : decoded word, stable between loads
// -----------------------------------------------------------------------------
import fc_pkg::*;

module fc_rate_lane #(
    parameter int WIN_LOG = DEF_WIN_LOG,
    parameter int INWD    = DEF_INWD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_sample,
    input  logic            i_bit,
    input  logic            i_load,
    output logic [INWD-1:0] o_out
);

    // WIN_LOG+1 bits so a full window of ones (N) is representable.
    logic [WIN_LOG:0] r_cnt;
    logic [WIN_LOG:0] w_sum;
    logic [INWD:0]    w_ext;
    logic [INWD-1:0]  w_sat;
    logic [INWD-1:0]  r_out;

    assign w_sum = r_cnt + {{WIN_LOG{1'b0}}, i_bit};

    // Zero-extend to INWD+1 bits; the top bit can only be set when the count
    // equals N and WIN_LOG == INWD, which is exactly the saturation case.
    assign w_ext = (INWD+1)'(w_sum);
    assign w_sat = w_ext[INWD] ? {INWD{1'b1}} : w_ext[INWD-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_sample) begin
            r_cnt <= w_sum;
        end
    end

    // NOTE: the output word is reset explicitly; readback after reset must see
    // zero, not whatever the previous window left behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (i_load) begin
            r_out <= w_sat;
        end
    end

    assign o_out = r_out;

endmodule : fc_rate_lane

// File: rtl/fc_rate_decoder.sv
// -----------------------------------------------------------------------------
// fc_rate_decoder
//   Converts DIM parallel rate-coded bitstreams back into INWD-bit binary words
//   by counting ones over a window of N = 2^WIN_LOG enabled samples. Results
//   are presented through a valid/ready handshake.
//
//   clk        in  : clock, rising edge
//   rst        in  : asynchronous active-high reset
//   enable     in  : sample strobe; low freezes the window
//   start      in  : begin a new window (clears all counters)
//   bit_in     in  : one stream bit per lane
//   out_valid  out : decoded words available (registered, HOLD state)
//   out_ready  in  : consumer accepts the words
//   out        out : decoded words, one per lane
// -----------------------------------------------------------------------------
import fc_pkg::*;

module fc_rate_decoder #(
    parameter int DIM     = 16,
    parameter int INWD    = DEF_INWD,
    parameter int WIN_LOG = DEF_WIN_LOG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      start,
    input  logic [DIM-1:0]            bit_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIM-1:0][INWD-1:0]  out
);

    // Window counter value while the N-th sample is being taken.
    localparam logic [WIN_LOG:0] LP_LAST = (WIN_LOG+1)'((1 << WIN_LOG) - 1);

    dec_state_t       r_state;
    dec_state_t       w_state_nxt;
    logic [WIN_LOG:0] r_win_cnt;

    logic w_clear;
    logic w_sample;
    logic w_last;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = COUNT;
            end
            COUNT: begin
                if (w_last) w_state_nxt = HOLD;
            end
            HOLD: begin
                // start without out_ready is ignored: the result must be taken first.
                if (out_ready) w_state_nxt = start ? COUNT : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_clear   = 1'b0;
        w_sample  = 1'b0;
        w_last    = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear = start;
            end
            COUNT: begin
                // A restart discards the current bit rather than sampling it.
                w_clear  = start;
                w_sample = enable & ~start;
                w_last   = w_sample & (r_win_cnt == LP_LAST);
            end
            HOLD: begin
                out_valid = 1'b1;
                w_clear   = out_ready & start;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------- window counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt <= '0;
        end else if (w_clear) begin
            r_win_cnt <= '0;
        end else if (w_sample) begin
            r_win_cnt <= r_win_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------- lanes
    for (genvar g = 0; g < DIM; g++) begin : g_lane
        fc_rate_lane #(
            .WIN_LOG (WIN_LOG),
            .INWD    (INWD)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (w_clear),
            .i_sample (w_sample),
            .i_bit    (bit_in[g]),
            .i_load   (w_last),
            .o_out    (out[g])
        );
    end

endmodule : fc_rate_decoder

// File: tb/tb_fc_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_fc_rate_decoder
//   Directed testbench for fc_rate_decoder with default parameters
//   (DIM=16, INWD=8, WIN_LOG=8, N=256).
// -----------------------------------------------------------------------------
module tb_fc_rate_decoder;

    localparam int DIM     = 16;
    localparam int INWD    = 8;
    localparam int WIN_LOG = 8;
    localparam int BUDGET  = 400;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic                     start;
    logic [DIM-1:0]           bit_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [DIM-1:0][INWD-1:0] out;

    int cyc     = 0;
    int n_check = 0;
    int n_pass  = 0;

    fc_rate_decoder #(
        .DIM     (DIM),
        .INWD    (INWD),
        .WIN_LOG (WIN_LOG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .start     (start),
        .bit_in    (bit_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_check++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Three enable gaps: 10 + 15 + 15 = 40 cycles.
    function automatic logic gap_off(input int c);
        return (c >= 11 && c <= 20) || (c >= 101 && c <= 115) || (c >= 201 && c <= 215);
    endfunction

    // Stream bits for sample index s (count of enabled samples already taken).
    function automatic logic [DIM-1:0] stim(input int mode, input int s, input logic en);
        logic [DIM-1:0] b;
        logic [7:0]     s8;
        b  = '0;
        s8 = s[7:0];
        case (mode)
            0: begin
                b[0]  = 1'b1;                    // all ones -> saturates at 255
                b[1]  = 1'b0;                    // all zeros -> 0
                b[2]  = (s % 2 == 0);            // 1010... -> 128
                b[3]  = (bitrev8(s8) < 8'd77);   // bit-reversed comparator BSG -> 77
                b[4]  = (s < 100);               // -> 100
                b[15] = 1'b1;                    // highest lane, saturates
            end
            1: begin
                b[0] = en && (s < 100);          // ones only while enabled -> 100
                b[1] = 1'b1;                     // ones in gaps too -> 255
                b[2] = !en;                      // ones only in gaps -> 0
            end
            default: begin
                b[0] = 1'b0;                     // -> 0
                b[1] = 1'b1;                     // -> 255
                b[2] = (s % 4 == 0);             // -> 64
                b[3] = (s < 200);                // -> 200
                b[4] = (s != 0);                 // 255 ones, no saturation -> 255
            end
        endcase
        return b;
    endfunction

    function automatic logic [7:0] exp_word(input int mode, input int lane);
        case (mode)
            0: case (lane)
                   0: return 8'd255;  2: return 8'd128;  3: return 8'd77;
                   4: return 8'd100; 15: return 8'd255;  default: return 8'd0;
               endcase
            1: case (lane)
                   0: return 8'd100;  1: return 8'd255;  default: return 8'd0;
               endcase
            default: case (lane)
                   1: return 8'd255;  2: return 8'd64;   3: return 8'd200;
                   4: return 8'd255;  default: return 8'd0;
               endcase
        endcase
    endfunction

    // Assumes the window was just opened; returns edges until out_valid.
    task automatic run_window(input int mode, output int cycles);
        int   s;
        logic en;
        s      = 0;
        cycles = BUDGET;
        for (int c = 1; c <= BUDGET; c++) begin
            en     = (mode == 1) ? !gap_off(c) : 1'b1;
            enable = en;
            bit_in = stim(mode, s, en);
            step();
            if (en) s++;
            if (out_valid) begin
                cycles = c;
                break;
            end
        end
        enable = 1'b0;
        bit_in = '0;
    endtask

    task automatic check_outs(input int mode);
        for (int i = 0; i < DIM; i++)
            check($sformatf("m%0d_out%0d", mode, i), 32'(out[i]), 32'(exp_word(mode, i)));
    endtask

    task automatic start_edge();
        start  = 1'b1;
        enable = 1'b1;
        bit_in = '1;      // must not be counted
        step();
        start  = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        int t_first;
        int t_second;

        rst = 1'b1; enable = 1'b0; start = 1'b0; out_ready = 1'b0; bit_in = '0;
        step(); step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_out", 32'(|out), 0);
        rst = 1'b0;
        step();

        // IDLE ignores bits and enable without start.
        for (int k = 0; k < 10; k++) begin
            enable = 1'b1; bit_in = (k % 2) ? '1 : 16'h5A5A;
            step();
        end
        check("idle_no_valid", 32'(out_valid), 0);
        enable = 1'b0; bit_in = '0;

        // Window A: patterns and latency.
        start_edge();
        run_window(0, n);
        check("m0_latency", n, 256);
        check_outs(0);

        // Backpressure: bits toggle, start pulses, out_ready low.
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            out_ready = 1'b0;
            enable    = 1'b1;
            bit_in    = (k % 2) ? 16'hFFFF : 16'h0000;
            start     = (k % 7 == 0);
            step();
            if (out_valid !== 1'b1) bad++;
            for (int i = 0; i < DIM; i++) if (out[i] !== exp_word(0, i)) bad++;
        end
        start = 1'b0; enable = 1'b0; bit_in = '0;
        check("bp_bad_cycles", bad, 0);

        // Accept without start -> IDLE, words retained.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("accept_to_idle", 32'(out_valid), 0);
        check("out_kept_idle", 32'(out[3]), 77);

        // Window B: enable gaps.
        start_edge();
        run_window(1, n);
        check("m1_latency", n, 296);
        check_outs(1);

        // Back-to-back: accept and start in the same HOLD cycle.
        t_first   = cyc;
        out_ready = 1'b1;
        start     = 1'b1;
        enable    = 1'b1;
        bit_in    = '1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check("b2b_restart", 32'(out_valid), 0);
        run_window(2, n);
        t_second = cyc;
        check("m2_latency", n, 256);
        check("b2b_spacing", t_second - t_first, 257);
        check_outs(2);

        // Reset in the middle of a window.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start_edge();
        for (int k = 0; k < 120; k++) begin
            enable = 1'b1;
            bit_in = stim(0, k, 1'b1);
            step();
        end
        rst = 1'b1;
        #2;
        check("rst_async_valid", 32'(out_valid), 0);
        check("rst_async_out", 32'(|out), 0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            enable = 1'b1; bit_in = '1;
            step();
            if (out_valid) break;
        end
        check("rst_idle", 32'(out_valid), 0);
        enable = 1'b0; bit_in = '0;
        start_edge();
        run_window(0, n);
        check("post_rst_latency", n, 256);
        check_outs(0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule : tb_fc_rate_decoder
